// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch buffer entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush
//   push/push_data enqueue; pop dequeues, pop_data is the head (valid when !empty)
//   flush empties the FIFO and wins over push/pop; count/full/empty report occupancy
//   reset: asynchronous, active-low
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage - fetch PC, imem request/response, response FIFO, IF/ID register
//   in : clk, reset (async active-low), redirect_valid_E/redirect_pc_E, stall_D, flush_D,
//        imem_req_ready, imem_rsp_valid, imem_rsp_data
//   out: imem_req_valid, imem_req_addr, PC_F, Instr_D, PC_D, PCPlus4_D, valid_D
//   IFETCH_PERF_EN adds fetch_bubble_cnt (saturating count of empty-FIFO bubbles)
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid_E,
  input  logic [XLEN-1:0] redirect_pc_E,
  input  logic            stall_D,
  input  logic            flush_D,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] PC_F,
  output logic [XLEN-1:0] Instr_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
`ifdef IFETCH_PERF_EN
  output logic [31:0]     fetch_bubble_cnt,
`endif
  output logic            valid_D
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t head, entry_in;
  logic [CW-1:0] fifo_count, outstanding, drop_cnt;
  logic [CW:0] in_use;
  logic [XLEN-1:0] pc_q [FIFO_DEPTH];
  logic [AW-1:0] q_head, q_tail;
  logic fifo_full, fifo_empty, kill, pop, push, dropping, issue;
  assign kill = flush_D | redirect_valid_E;
  assign pop = ~kill & ~stall_D & ~fifo_empty;
  assign dropping = drop_cnt != '0;
  assign push = imem_rsp_valid & ~dropping;
  assign entry_in = {imem_rsp_data, pc_q[q_head]};
  // occupancy after this cycle's pop, so a 1-cycle memory sustains one fetch per cycle
  assign in_use = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = reset & ~redirect_valid_E & ~(fifo_full & ~pop) & (in_use < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr = PC_F;
  assign issue = imem_req_valid & imem_req_ready;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(entry_in),
    .pop(pop),
    .flush(redirect_valid_E),
    .pop_data(head),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  // pc_q holds the PC of every in-flight request, including ones that will be dropped
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      PC_F <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      q_head <= '0;
      q_tail <= '0;
    end else begin
      PC_F <= redirect_valid_E ? (redirect_pc_E & ~XLEN'(3)) : issue ? PC_F + XLEN'(4) : PC_F;
      outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
      drop_cnt <= redirect_valid_E ? outstanding - CW'(imem_rsp_valid) : drop_cnt - CW'(imem_rsp_valid & dropping);
      q_tail <= q_tail + AW'(issue);
      q_head <= q_head + AW'(imem_rsp_valid);
    end
  always_ff @(posedge clk)
    if (issue) pc_q[q_tail] <= PC_F;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      Instr_D <= NOP_INSTR;
      PC_D <= '0;
      PCPlus4_D <= '0;
      valid_D <= 1'b0;
    end else if (kill) begin
      Instr_D <= NOP_INSTR;
      valid_D <= 1'b0;
    end else if (!stall_D) begin
      Instr_D <= pop ? head.instr : NOP_INSTR;
      valid_D <= pop;
      if (pop) begin
        PC_D <= head.pc;
        PCPlus4_D <= head.pc + XLEN'(4);
      end
    end
`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) fetch_bubble_cnt <= '0;
    else if (!kill && !stall_D && fifo_empty && fetch_bubble_cnt != '1) fetch_bubble_cnt <= fetch_bubble_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, redirect_valid_E, stall_D, flush_D, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc_E, imem_rsp_data;
  logic imem_req_valid, valid_D, w_req_valid, w_valid_D;
  logic [31:0] imem_req_addr, PC_F, Instr_D, PC_D, PCPlus4_D;
  logic [31:0] w_addr, w_PC_F, w_Instr_D, w_PC_D, w_PCPlus4_D;
`ifdef IFETCH_PERF_EN
  logic [31:0] bubbles, w_bubbles;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;
  fetch_stage dut (
    .clk(clk), .reset(reset), .redirect_valid_E(redirect_valid_E), .redirect_pc_E(redirect_pc_E),
    .stall_D(stall_D), .flush_D(flush_D), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
`ifdef IFETCH_PERF_EN
    .fetch_bubble_cnt(bubbles),
`endif
    .valid_D(valid_D)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .redirect_valid_E(redirect_valid_E), .redirect_pc_E(redirect_pc_E),
    .stall_D(stall_D), .flush_D(flush_D), .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .PC_F(w_PC_F), .Instr_D(w_Instr_D), .PC_D(w_PC_D), .PCPlus4_D(w_PCPlus4_D),
`ifdef IFETCH_PERF_EN
    .fetch_bubble_cnt(w_bubbles),
`endif
    .valid_D(w_valid_D)
  );
  int n_cmp = 0;
  int n_err = 0;
  int lat = 1;
  logic pv [4];
  logic [31:0] pa [4];
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0000_0093 + (a >> 2) * 32'h0010_0080;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic expect_d(input string tag, input logic [31:0] pc);
    check({tag, "_pc"}, PC_D, pc);
    check({tag, "_instr"}, Instr_D, word(pc));
    check({tag, "_pc4"}, PCPlus4_D, pc + 32'd4);
    check({tag, "_valid"}, 32'(valid_D), 32'd1);
  endtask
  task automatic expect_bubble(input string tag);
    check({tag, "_instr"}, Instr_D, NOP);
    check({tag, "_valid"}, 32'(valid_D), 32'd0);
  endtask
  // memory model: in-order responses lat cycles after each accepted request
  task automatic tick();
    logic hs;
    logic [31:0] a;
    #1;
    hs = imem_req_valid & imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = hs;
    pa[0] = a;
    imem_rsp_valid = pv[lat-1];
    imem_rsp_data = word(pa[lat-1]);
  endtask
  initial begin
    reset = 1'b0; redirect_valid_E = 1'b0; redirect_pc_E = '0; stall_D = 1'b0; flush_D = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    tick(); tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_pc_f", PC_F, 32'h0);
    check("rst_instr", Instr_D, NOP);
    check("rst_pc_d", PC_D, 32'h0);
    check("rst_pc4_d", PCPlus4_D, 32'h0);
    check("rst_valid", 32'(valid_D), 32'd0);
    check("w_rst_pc_f", w_PC_F, 32'hFFFF_FFF8);
    reset = 1'b1;
    #1;
    check("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("c0_addr", imem_req_addr, 32'h0);
    check("w_c0_addr", w_addr, 32'hFFFF_FFF8);
    tick(); #1;
    check("c1_addr", imem_req_addr, 32'h4);
    check("c1_pc_f", PC_F, 32'h4);
    check("w_c1_addr", w_addr, 32'hFFFF_FFFC);
    tick(); #1;
    check("c2_addr", imem_req_addr, 32'h8);
    check("c2_valid", 32'(valid_D), 32'd0);
    check("w_c2_addr", w_addr, 32'h0);
`ifdef IFETCH_PERF_EN
    check("perf_start", bubbles, 32'd2);
`endif
    tick();
    expect_d("e2", 32'h0);
    check("w_e2_pc_d", w_PC_D, 32'hFFFF_FFF8);
    tick();
    expect_d("e3", 32'h4);
    check("w_e3_pc4", w_PCPlus4_D, 32'h0);
    tick();
    expect_d("e4", 32'h8);
    stall_D = 1'b1;
    #1;
    check("stall_req0", 32'(imem_req_valid), 32'd0);
    tick(); #1;
    check("stall1_pc_d", PC_D, 32'h8);
    check("stall1_instr", Instr_D, word(32'h8));
    check("stall1_req", 32'(imem_req_valid), 32'd0);
    tick(); tick();
    check("stall3_pc_d", PC_D, 32'h8);
    check("stall3_instr", Instr_D, word(32'h8));
    stall_D = 1'b0;
    tick(); expect_d("rel0", 32'hC);
    tick(); expect_d("rel1", 32'h10);
    tick(); expect_d("rel2", 32'h14);
    flush_D = 1'b1; stall_D = 1'b1;
    tick();
    expect_bubble("flush_stall");
    check("flush_stall_pc_d", PC_D, 32'h14);
    flush_D = 1'b0; stall_D = 1'b0;
    tick(); expect_d("post_flush", 32'h18);
`ifdef IFETCH_PERF_EN
    check("perf_no_flush_count", bubbles, 32'd2);
`endif
    #3;
    reset = 1'b0;
    #1;
    check("arst_req_valid", 32'(imem_req_valid), 32'd0);
    check("arst_pc_f", PC_F, 32'h0);
    check("arst_instr", Instr_D, NOP);
    check("arst_pc_d", PC_D, 32'h0);
    check("arst_pc4_d", PCPlus4_D, 32'h0);
    check("arst_valid", 32'(valid_D), 32'd0);
`ifdef IFETCH_PERF_EN
    check("arst_perf", bubbles, 32'd0);
`endif
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    imem_rsp_valid = 1'b0;
    lat = 2;
    tick();
    reset = 1'b1;
    #1;
    check("l2_c0_addr", imem_req_addr, 32'h0);
    tick(); tick(); tick(); tick();
    expect_d("l2_e3", 32'h0);
    tick();
    expect_d("l2_e4", 32'h4);
    redirect_valid_E = 1'b1; redirect_pc_E = 32'h0000_0042;
    #1;
    check("redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid_E = 1'b0;
    check("redir_pc_f", PC_F, 32'h40);
    check("redir_pc_d_hold", PC_D, 32'h4);
    expect_bubble("redir_e5");
    #1;
    check("redir_new_addr", imem_req_addr, 32'h40);
    check("redir_new_req", 32'(imem_req_valid), 32'd1);
    tick(); expect_bubble("redir_e6");
    tick(); expect_bubble("redir_e7");
    tick(); expect_bubble("redir_e8");
    tick(); expect_d("redir_e9", 32'h40);
    tick(); expect_d("redir_e10", 32'h44);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
